// File: rtl/dmem_responder_if.sv
// Data-port bus between the core (master) and the data-memory responder (slave).
// Latency: none, signal bundle only.
// Backpressure: the master holds its request until mem_ready; the slave never stalls mem_ready itself.
// Signals:
//   mem_read, mem_write, mem_addr[29:0], mem_wdata[31:0] : request, driven by the core
//   mem_rdata[31:0], mem_ready, busy                     : response, driven by the responder
interface dmem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        busy;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready, busy
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory for the core's data port, fixed access latency.
// Latency: mem_ready is high LATENCY cycles after the request is first seen in IDLE; issue interval LATENCY+1.
// Backpressure: requests are held by the core; a request seen outside IDLE waits until the FSM returns to IDLE.
// Ports:
//   clk            : clock, rising edge
//   rst            : asynchronous active-low reset
//   bus (slave)    : mem_read/mem_write/mem_addr/mem_wdata in; mem_rdata/mem_ready/busy out
// Build option: define DMEM_BYTE_SWAP_EN to keep the array image big-endian (bus stays little-endian).
module dmem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 4
) (
  input logic              clk,
  input logic              rst,
  dmem_responder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // WAIT spends CNT_INIT+1 cycles, so IDLE + WAIT + RESP entry lands mem_ready at cycle LATENCY.
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic        wr_q;
  logic [31:0] rdata_q;
  logic [31:0] mem_q [0:(1<<ADDR_W)-1];

  logic        req;
  logic        commit;
  logic [29:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_wr;
  logic        in_range;
  logic [ADDR_W-1:0] acc_idx;

  function automatic logic [31:0] swap_bytes(input logic [31:0] w);
`ifdef DMEM_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  assign req = bus.mem_read | bus.mem_write;

  // With LATENCY==1 the commit happens on the accepting edge, before the
  // request is latched, so the live inputs are used while in IDLE.
  assign acc_addr  = (state_q == IDLE) ? bus.mem_addr  : addr_q;
  assign acc_wdata = (state_q == IDLE) ? bus.mem_wdata : wdata_q;
  assign acc_wr    = (state_q == IDLE) ? bus.mem_write : wr_q;
  assign in_range  = (acc_addr[29:ADDR_W] == '0);
  assign acc_idx   = acc_addr[ADDR_W-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (LATENCY == 1) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req) begin
        addr_q  <= bus.mem_addr;
        wdata_q <= bus.mem_wdata;
        wr_q    <= bus.mem_write;
      end
      // Read+write together counts as a write, so rdata is left alone.
      if (commit && !acc_wr) begin
        rdata_q <= in_range ? swap_bytes(mem_q[acc_idx]) : 32'h0;
      end
    end
  end

  // Array is deliberately not reset; the rst gate keeps an access that is
  // being aborted from committing.
  always_ff @(posedge clk) begin
    if (rst && commit && acc_wr && in_range) begin
      mem_q[acc_idx] <= swap_bytes(acc_wdata);
    end
  end

  assign bus.mem_ready = (state_q == RESP);
  assign bus.busy      = (state_q != IDLE);
  assign bus.mem_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance at LATENCY=4, one at LATENCY=1.
// Drivers push the expected response into a queue; negedge monitors pop and compare.
module tb_dmem_responder;
  localparam int L4 = 4;
  localparam int L1 = 1;

  typedef struct {
    logic [31:0] rdata;
    int          issue;
    string       tag;
  } exp_t;

  logic clk;
  logic rst4, rst1;
  int   cyc;
  int   n_chk, n_pass, n_fail;
  bit   done4, done1;
  exp_t q4[$];
  exp_t q1[$];
  exp_t e4, e1;

  dmem_responder_if if4();
  dmem_responder_if if1();

  dmem_responder #(.ADDR_W(8), .LATENCY(L4)) u_dut4 (.clk(clk), .rst(rst4), .bus(if4.slave));
  dmem_responder #(.ADDR_W(8), .LATENCY(L1)) u_dut1 (.clk(clk), .rst(rst1), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic fail_timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s_timeout: mem_ready not seen, expected within budget", nm);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (if4.mem_ready) begin
      if (q4.size() == 0) begin
        chk("dut4_unexpected_ready", 32'd1, 32'd0);
      end else begin
        e4 = q4.pop_front();
        chk({e4.tag, "_rdata"}, if4.mem_rdata, e4.rdata);
        chk({e4.tag, "_latency"}, 32'(cyc - e4.issue), 32'(L4));
        chk({e4.tag, "_busy"}, {31'd0, if4.busy}, 32'd1);
      end
    end
  end

  always @(negedge clk) begin
    if (if1.mem_ready) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_ready", 32'd1, 32'd0);
      end else begin
        e1 = q1.pop_front();
        chk({e1.tag, "_rdata"}, if1.mem_rdata, e1.rdata);
        chk({e1.tag, "_latency"}, 32'(cyc - e1.issue), 32'(L1));
      end
    end
  end

  // ---------------- drivers ----------------
  // Called just after a rising edge; returns just after the edge that ends the RESP cycle.
  task automatic acc4(input logic rd, input logic wr, input logic [29:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input string tag);
    bit seen;
    if4.mem_read  = rd;
    if4.mem_write = wr;
    if4.mem_addr  = a;
    if4.mem_wdata = wd;
    q4.push_back('{rdata: exp_rd, issue: cyc, tag: tag});
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (if4.mem_ready) seen = 1'b1;
    end
    if (!seen) begin
      fail_timeout(tag);
      q4.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic acc1(input logic rd, input logic wr, input logic [29:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input string tag);
    bit seen;
    if1.mem_read  = rd;
    if1.mem_write = wr;
    if1.mem_addr  = a;
    if1.mem_wdata = wd;
    q1.push_back('{rdata: exp_rd, issue: cyc, tag: tag});
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (if1.mem_ready) seen = 1'b1;
    end
    if (!seen) begin
      fail_timeout(tag);
      q1.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle4();
    if4.mem_read = 1'b0; if4.mem_write = 1'b0; if4.mem_addr = '0; if4.mem_wdata = '0;
  endtask

  task automatic idle1();
    if1.mem_read = 1'b0; if1.mem_write = 1'b0; if1.mem_addr = '0; if1.mem_wdata = '0;
  endtask

  // ---------------- LATENCY=4 sequence ----------------
  initial begin
    logic [31:0] img;
    rst4 = 1'b0;
    idle4();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, if4.mem_ready}, 32'd0);
    chk("rst_busy",  {31'd0, if4.busy},      32'd0);
    chk("rst_rdata", if4.mem_rdata,          32'h0);
    rst4 = 1'b1;
    @(posedge clk);
    #1;

    acc4(1'b0, 1'b1, 30'd0,     32'hA5A5_0000, 32'h0,         "w_addr0");
    acc4(1'b0, 1'b1, 30'd5,     32'h5555_AAAA, 32'h0,         "w_addr5");
    acc4(1'b0, 1'b1, 30'd128,   32'h7856_3412, 32'h0,         "w_addr128");
    acc4(1'b1, 1'b0, 30'd128,   32'h0,         32'h7856_3412, "r_addr128");
    acc4(1'b0, 1'b1, 30'h100,   32'hDEAD_BEEF, 32'h7856_3412, "w_oor");
    acc4(1'b1, 1'b0, 30'h100,   32'h0,         32'h0,         "r_oor");
    acc4(1'b1, 1'b0, 30'd0,     32'h0,         32'hA5A5_0000, "r_addr0_after_oor");
    acc4(1'b1, 1'b1, 30'd3,     32'h0000_0011, 32'hA5A5_0000, "rw_addr3");
    acc4(1'b1, 1'b0, 30'd3,     32'h0,         32'h0000_0011, "r_addr3");
    acc4(1'b0, 1'b1, 30'h20,    32'h0403_0201, 32'h0000_0011, "w_addr32");
`ifdef DMEM_BYTE_SWAP_EN
    img = 32'h0102_0304;
`else
    img = 32'h0403_0201;
`endif
    chk("array_image_addr32", u_dut4.mem_q[32], img);
    acc4(1'b1, 1'b0, 30'h20,    32'h0,         32'h0403_0201, "r_addr32");

    // Write to addr 5 aborted by reset while in WAIT; no response is queued.
    if4.mem_read  = 1'b0;
    if4.mem_write = 1'b1;
    if4.mem_addr  = 30'd5;
    if4.mem_wdata = 32'hBAD0_BAD0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst4 = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, if4.mem_ready}, 32'd0);
    chk("midrst_busy",  {31'd0, if4.busy},      32'd0);
    chk("midrst_rdata", if4.mem_rdata,          32'h0);
    idle4();
    @(posedge clk);
    #1;
    rst4 = 1'b1;
    @(posedge clk);
    #1;
    acc4(1'b1, 1'b0, 30'd5, 32'h0, 32'h5555_AAAA, "r_addr5_after_rst");
    idle4();
    done4 = 1'b1;
  end

  // ---------------- LATENCY=1 sequence ----------------
  initial begin
    logic [31:0] tbl [8];
    tbl = '{32'h0000_0011, 32'h0000_2200, 32'h0033_0000, 32'h4400_0000,
            32'h1234_5678, 32'h9ABC_DEF0, 32'hFFFF_0001, 32'h8000_0080};
    rst1 = 1'b0;
    idle1();
    repeat (2) @(posedge clk);
    #1;
    rst1 = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++)
      acc1(1'b0, 1'b1, 30'(i), tbl[i], 32'h0, $sformatf("l1_w%0d", i));
    // mem_read stays high across the whole read burst.
    for (int i = 0; i < 8; i++)
      acc1(1'b1, 1'b0, 30'(i), 32'h0, tbl[i], $sformatf("l1_r%0d", i));
    idle1();
    done1 = 1'b1;
  end

  // ---------------- summary ----------------
  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0;
    done4 = 1'b0; done1 = 1'b0;
    for (int t = 0; t < 3000 && !(done4 && done1); t++) @(posedge clk);
    if (!(done4 && done1)) begin
      n_chk++;
      n_fail++;
      $display("FAIL sequence_timeout: done4=%0d done1=%0d expected both 1", done4, done1);
    end
    repeat (3) @(posedge clk);
    chk("dut4_queue_drained", 32'(q4.size()), 32'd0);
    chk("dut1_queue_drained", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
